// File: rtl/if_prefetch_unit_pkg.sv
// Shared fetch-stage definitions: exception code width and values, reset PC, zero word.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package if_prefetch_unit_pkg;

  localparam int          EXC_CODE_BUS = 5;
  localparam logic [4:0]  EXC_NONE     = 5'h00;
  localparam logic [4:0]  EXC_ADEL     = 5'h04;
  localparam logic [31:0] PC_INIT      = 32'hbfc0_0000;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  typedef logic [EXC_CODE_BUS-1:0] exc_code_t;

endpackage

// File: rtl/if_inst_fifo.sv
// Generic synchronous FIFO used for the prefetch data queue and the request-PC queue.
// Latency: push in cycle N is visible at rdata_o in N+1; rdata_o always shows the head (no bypass).
// Backpressure: push while full is accepted only together with a pop; clear has priority over both.
//
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/wdata_i write side;
//        pop_i read side; clear_i drops all entries; rdata_o head entry;
//        full_o/empty_o/count_o occupancy.
module if_inst_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  input  logic                         clear_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  // Explicit wrap so non-power-of-two depths work as well.
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || pop_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ptr_next(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_next(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: in-order bus requests, DEPTH-entry prefetch queue, {pc, inst, exccode} to decode.
// Latency: data_ok in cycle N gives out_valid in N+1; flush/redirect in N gives out_valid=0 in N+1.
// Backpressure: out_ready low stalls the queue; issue stops once queued + outstanding reaches DEPTH.
//
// Ports: cpu_clk_50M/cpu_rst_n clock and async active-low reset; flush/cp0_excaddr and
//        redirect_valid/redirect_pc restart fetch (flush wins); inst_* is the SRAM-like
//        request/response bus; out_* is the valid/ready interface to decode.
module if_prefetch_unit
  import if_prefetch_unit_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 4,
  parameter int                MAX_OUTST = 2,
  parameter logic [ADDR_W-1:0] PC_INIT   = ADDR_W'(if_prefetch_unit_pkg::PC_INIT),
  parameter logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(32'h1fff_ffff)
) (
  input  logic                    cpu_clk_50M,
  input  logic                    cpu_rst_n,
  input  logic                    flush,
  input  logic [ADDR_W-1:0]       cp0_excaddr,
  input  logic                    redirect_valid,
  input  logic [ADDR_W-1:0]       redirect_pc,
  output logic                    inst_req,
  output logic [ADDR_W-1:0]       inst_addr,
  input  logic                    inst_addr_ok,
  input  logic                    inst_data_ok,
  input  logic [31:0]             inst_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_W-1:0]       out_pc,
  output logic [31:0]             out_inst,
  output logic [EXC_CODE_BUS-1:0] out_exccode
);

  localparam int QW  = ADDR_W + 32 + EXC_CODE_BUS;
  localparam int OW  = $clog2(MAX_OUTST + 1);
  localparam int QCW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, pend_pc_q, req_pc, new_pc, rq_pc;
  logic [OW-1:0]     discard_q, discard_d, rq_cnt;
  logic [QCW-1:0]    q_cnt;
  logic [QW-1:0]     q_wdata, q_rdata;
  logic              halted_q, halted_d, run_q, pend_q, pend_d, stale_q, stale_d;
  logic              restart, issue_ok, accept, acc_stale, data_live, drop;
  logic              data_enq, exc_enq, deq, q_full, q_empty, rq_full, rq_empty;

  assign restart = flush | redirect_valid;
  assign new_pc  = flush ? cp0_excaddr : redirect_pc;

  // Outstanding requests already reserve queue slots, so returning data never overflows.
  assign issue_ok = run_q && !halted_q && (fetch_pc_q[1:0] == 2'b00) && !rq_full &&
                    ((32'(q_cnt) + 32'(rq_cnt)) < DEPTH);

  // A request that has been shown to the bus is held, address unchanged, until accepted.
  assign inst_req  = pend_q | issue_ok;
  assign req_pc    = pend_q ? pend_pc_q : fetch_pc_q;
  assign inst_addr = req_pc & ADDR_MASK;

  assign accept    = inst_req && inst_addr_ok;
  // A held request from before a restart belongs to the old stream: its data is dropped.
  assign acc_stale = accept && pend_q && stale_q;
  assign data_live = inst_data_ok && !rq_empty;
  assign drop      = data_live && (discard_q != '0);
  assign data_enq  = data_live && !drop;

  assign deq       = !q_empty && out_ready;
  // Only raise the address error once every earlier fetch has drained, so order is kept.
  assign exc_enq   = run_q && !halted_q && !restart && (fetch_pc_q[1:0] != 2'b00) &&
                     !pend_q && rq_empty && (!q_full || deq);

  assign q_wdata = data_enq ? {rq_pc, inst_rdata, EXC_NONE}
                            : {fetch_pc_q, ZERO_WORD, EXC_ADEL};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q - OW'(drop) + OW'(acc_stale);
    halted_d   = halted_q | exc_enq;
    pend_d     = inst_req && !inst_addr_ok;
    stale_d    = pend_d && (stale_q || restart);
    if (accept && !acc_stale) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    if (restart) begin
      fetch_pc_d = new_pc;
      // Everything still in flight after this edge belongs to the old stream.
      discard_d  = rq_cnt + OW'(accept) - OW'(data_live);
      halted_d   = 1'b0;
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      fetch_pc_q <= PC_INIT;
      pend_pc_q  <= PC_INIT;
      discard_q  <= '0;
      halted_q   <= 1'b0;
      run_q      <= 1'b0;
      pend_q     <= 1'b0;
      stale_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= req_pc;
      discard_q  <= discard_d;
      halted_q   <= halted_d;
      run_q      <= 1'b1;
      pend_q     <= pend_d;
      stale_q    <= stale_d;
    end
  end

  // PCs of accepted requests, popped in order as responses return.
  if_inst_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUTST)) u_req_pc_fifo (
    .clk_i   (cpu_clk_50M),
    .rst_ni  (cpu_rst_n),
    .push_i  (accept),
    .wdata_i (req_pc),
    .pop_i   (data_live),
    .clear_i (1'b0),
    .rdata_o (rq_pc),
    .full_o  (rq_full),
    .empty_o (rq_empty),
    .count_o (rq_cnt)
  );

  if_inst_fifo #(.WIDTH(QW), .DEPTH(DEPTH)) u_data_fifo (
    .clk_i   (cpu_clk_50M),
    .rst_ni  (cpu_rst_n),
    .push_i  (data_enq | exc_enq),
    .wdata_i (q_wdata),
    .pop_i   (deq),
    .clear_i (restart),
    .rdata_o (q_rdata),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_cnt)
  );

  assign out_valid   = !q_empty;
  assign out_pc      = q_rdata[QW-1 -: ADDR_W];
  assign out_inst    = q_rdata[EXC_CODE_BUS +: 32];
  assign out_exccode = q_rdata[EXC_CODE_BUS-1:0];

endmodule
